// File: rtl/decode_stage.sv
// decode_stage: instruction decode + operand fetch with 16x32 register file; define DECODE_BYPASS_EN to forward same-cycle writeback into operands
module decode_stage #(
  parameter int RF_DEPTH = 16,
  parameter int IMM_W = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] st_data,
  output logic [3:0]  rd,
  output logic        isadd,
  output logic        isld,
  output logic        isst,
  output logic        issub,
  output logic        iscmp,
  output logic        ismul,
  output logic        islsl,
  output logic        islsr,
  output logic        isasr,
  output logic        isor,
  output logic        isnot,
  output logic        isand,
  output logic        isdiv,
  output logic        ismod,
  output logic        ismov,
  output logic        illegal_op,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data
);
`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [31:0] rf [RF_DEPTH];
  logic [4:0]  opc;
  logic [3:0]  rs1, rs2, rdi, idx;
  logic [31:0] simm, ra, rb, rs;
  logic [14:0] op_q, oh;
  logic        accept, legal, mem, fwd;
  assign opc = in_instr[31:27];
  assign rdi = in_instr[25:22];
  assign rs1 = in_instr[21:18];
  assign rs2 = in_instr[17:14];
  assign simm = {{(32-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign legal = !opc[4] && opc[3:0] != 4'd13;
  assign mem = opc == 5'd14 || opc == 5'd15;
  assign fwd = BYPASS && wb_en;
  assign ra = fwd && wb_rd == rs1 ? wb_data : rf[rs1];
  assign rb = fwd && wb_rd == rs2 ? wb_data : rf[rs2];
  assign rs = fwd && wb_rd == rdi ? wb_data : rf[rdi];
  // opcode 13 (nop) has no control line, so opcodes above it shift down one slot
  assign idx = opc[3:0] > 4'd13 ? opc[3:0] - 4'd1 : opc[3:0];
  assign oh = 15'b1 << idx;
  assign {isst, isld, isasr, islsr, islsl, ismov, isnot, isor, isand, iscmp, ismod, isdiv, ismul, issub, isadd} = op_q;
  // register file: reset clears every entry, writeback never blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_rd] <= wb_data;
    end
  end
  // output register: load on accept, clear on consume, hold during stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      illegal_op <= 1'b0;
      op_q <= '0;
      a <= '0;
      b <= '0;
      st_data <= '0;
      rd <= '0;
    end else begin
      illegal_op <= accept && opc[4];
      if (accept) begin
        out_valid <= legal;
        op_q <= legal ? oh : '0;
        if (legal) begin
          a <= ra;
          b <= in_instr[26] || mem ? simm : rb;
          st_data <= rs;
          rd <= rdi;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        op_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage handshake, decode, stall, reset and writeback forwarding
module tb_decode_stage;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, wb_en = 0;
  logic [31:0] in_instr = 0, wb_data = 0;
  logic [3:0]  wb_rd = 0;
  logic        in_ready, out_valid, illegal_op;
  logic [31:0] a, b, st_data;
  logic [3:0]  rd;
  logic isadd, isld, isst, issub, iscmp, ismul, islsl, islsr, isasr, isor, isnot, isand, isdiv, ismod, ismov;
  logic [14:0] ops;
  int pass = 0, total = 0;
  assign ops = {isst, isld, isasr, islsr, islsl, ismov, isnot, isor, isand, iscmp, ismod, isdiv, ismul, issub, isadd};
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .st_data(st_data), .rd(rd),
    .isadd(isadd), .isld(isld), .isst(isst), .issub(issub), .iscmp(iscmp), .ismul(ismul),
    .islsl(islsl), .islsr(islsr), .isasr(isasr), .isor(isor), .isnot(isnot), .isand(isand),
    .isdiv(isdiv), .ismod(ismod), .ismov(ismov), .illegal_op(illegal_op),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  function automatic logic [31:0] rr(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    rr = {op, 1'b0, d, s1, s2, 14'b0};
  endfunction
  function automatic logic [31:0] ri(input logic [4:0] op, input logic i, input logic [3:0] d, input logic [3:0] s1, input logic [17:0] imm);
    ri = {op, i, d, s1, imm};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] r, input logic [31:0] v);
    wb_en = 1; wb_rd = r; wb_data = v;
    step();
    wb_en = 0;
  endtask
  task automatic issue(input logic [31:0] ins);
    in_valid = 1; in_instr = ins;
    step();
    in_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    step(); step();
    rst = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass++;
    total++; if ({a, b, st_data, rd} !== 100'd0) $display("FAIL reset_data got a=%h b=%h st=%h rd=%0d want 0", a, b, st_data, rd); else pass++;
    total++; if ({ops, illegal_op} !== 16'd0) $display("FAIL reset_ctrl got ops=%h ill=%0b want 0", ops, illegal_op); else pass++;
  endtask
  task automatic test_add();
    wr(1, 5); wr(2, 3);
    out_ready = 1;
    issue(rr(5'd0, 4'd3, 4'd1, 4'd2));
    total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %0b want 1", out_valid); else pass++;
    total++; if (ops !== 15'h0001) $display("FAIL add_ops got %h want 0001", ops); else pass++;
    total++; if (a !== 32'd5 || b !== 32'd3 || rd !== 4'd3) $display("FAIL add_operands got a=%0d b=%0d rd=%0d want 5 3 3", a, b, rd); else pass++;
    step();
    total++; if (out_valid !== 1'b0 || ops !== 15'h0) $display("FAIL add_consumed got v=%0b ops=%h want 0 0", out_valid, ops); else pass++;
    issue(ri(5'd0, 1'b1, 4'd7, 4'd1, 18'h3FFFE));
    total++; if (a !== 32'd5 || b !== 32'hFFFFFFFE) $display("FAIL addi_operands got a=%h b=%h want 5 fffffffe", a, b); else pass++;
  endtask
  task automatic test_back_to_back();
    in_valid = 1; in_instr = ri(5'd14, 1'b0, 4'd4, 4'd1, 18'h3FFFF);
    step();
    total++; if (ops !== 15'h2000 || b !== 32'hFFFFFFFF || a !== 32'd5) $display("FAIL ld got ops=%h a=%h b=%h want 2000 5 ffffffff", ops, a, b); else pass++;
    in_instr = ri(5'd15, 1'b0, 4'd2, 4'd1, 18'd8);
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || ops !== 15'h4000) $display("FAIL st_ctrl got v=%0b ops=%h want 1 4000", out_valid, ops); else pass++;
    total++; if (b !== 32'd8 || st_data !== 32'd3 || rd !== 4'd2) $display("FAIL st_data got b=%0d st=%0d rd=%0d want 8 3 2", b, st_data, rd); else pass++;
    step();
  endtask
  task automatic test_stall();
    out_ready = 0;
    issue(rr(5'd0, 4'd3, 4'd1, 4'd2));
    in_valid = 1; in_instr = rr(5'd1, 4'd8, 4'd2, 4'd1);
    wb_en = 1; wb_rd = 1; wb_data = 32'd9;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL stall_start got v=%0b rdy=%0b want 1 0", out_valid, in_ready); else pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      wb_en = 0;
      total++; if (in_ready !== 1'b0 || ops !== 15'h0001 || a !== 32'd5 || b !== 32'd3 || rd !== 4'd3) $display("FAIL stall_hold%0d got rdy=%0b ops=%h a=%0d b=%0d rd=%0d want 0 0001 5 3 3", i, in_ready, ops, a, b, rd); else pass++;
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %0b want 1", in_ready); else pass++;
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || ops !== 15'h0002 || a !== 32'd3 || b !== 32'd9 || rd !== 4'd8) $display("FAIL stall_next got v=%0b ops=%h a=%0d b=%0d rd=%0d want 1 0002 3 9 8", out_valid, ops, a, b, rd); else pass++;
    step();
    wr(1, 5);
  endtask
  task automatic test_illegal();
    issue(ri(5'd20, 1'b0, 4'd1, 4'd1, 18'd0));
    total++; if (illegal_op !== 1'b1 || out_valid !== 1'b0 || ops !== 15'h0) $display("FAIL illegal got ill=%0b v=%0b ops=%h want 1 0 0", illegal_op, out_valid, ops); else pass++;
    step();
    total++; if (illegal_op !== 1'b0) $display("FAIL illegal_pulse got %0b want 0", illegal_op); else pass++;
    in_valid = 1; in_instr = rr(5'd0, 4'd3, 4'd1, 4'd2);
    step();
    in_instr = rr(5'd13, 4'd0, 4'd0, 4'd0);
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b0 || illegal_op !== 1'b0 || ops !== 15'h0) $display("FAIL nop got v=%0b ill=%0b ops=%h want 0 0 0", out_valid, illegal_op, ops); else pass++;
  endtask
  task automatic test_bypass();
    logic [31:0] exp;
`ifdef DECODE_BYPASS_EN
    exp = 32'h55;
`else
    exp = 32'd5;
`endif
    wb_en = 1; wb_rd = 1; wb_data = 32'h55;
    issue(rr(5'd0, 4'd5, 4'd1, 4'd1));
    wb_en = 0;
    total++; if (a !== exp || b !== exp) $display("FAIL bypass got a=%h b=%h want %h", a, b, exp); else pass++;
    issue(rr(5'd0, 4'd5, 4'd1, 4'd1));
    total++; if (a !== 32'h55 || b !== 32'h55) $display("FAIL rf_after_wb got a=%h b=%h want 55", a, b); else pass++;
    step();
  endtask
  task automatic test_rst_mid();
    out_ready = 0;
    issue(rr(5'd0, 4'd3, 4'd1, 4'd2));
    rst = 1; in_valid = 1; in_instr = rr(5'd1, 4'd9, 4'd1, 4'd2);
    step();
    rst = 0; in_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0 || a !== 32'd0 || ops !== 15'h0) $display("FAIL rst_mid got v=%0b a=%h ops=%h want 0 0 0", out_valid, a, ops); else pass++;
    issue(rr(5'd9, 4'd6, 4'd1, 4'd1));
    total++; if (ops !== 15'h0200 || b !== 32'd0 || rd !== 4'd6) $display("FAIL mov_after_rst got ops=%h b=%h rd=%0d want 0200 0 6", ops, b, rd); else pass++;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_bypass();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
